// File: rtl/wm_pkg.sv
// Shared phase codes, timer state encoding and the mode-dependent phase duration
// lookup used by the washing-machine phase timer.
package wm_pkg;

    localparam logic [1:0] PH_SOAK  = 2'b00;
    localparam logic [1:0] PH_WASH  = 2'b01;
    localparam logic [1:0] PH_RINSE = 2'b10;
    localparam logic [1:0] PH_SPIN  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } timer_state_e;

    // mode1 wins over mode2 over mode3; no mode selected behaves like mode1.
    // mode2 doubles (saturating at the counter maximum), mode3 halves (never below 1).
    function automatic int unsigned dur_lookup(
        input logic        m1,
        input logic        m2,
        input logic        m3,
        input logic [1:0]  phase,
        input int unsigned soak_s,
        input int unsigned wash_s,
        input int unsigned rinse_s,
        input int unsigned spin_s,
        input int unsigned sec_w
    );
        int unsigned base;
        int unsigned max_v;
        int unsigned dur;
        max_v = (sec_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << sec_w) - 32'd1);
        case (phase)
            PH_SOAK:  base = soak_s;
            PH_WASH:  base = wash_s;
            PH_RINSE: base = rinse_s;
            default:  base = spin_s;
        endcase
        if (m1 || !(m2 || m3)) begin
            dur = base;
        end else if (m2) begin
            dur = (base > (max_v >> 1)) ? max_v : (base << 1);
        end else begin
            dur = (base < 32'd2) ? 32'd1 : (base >> 1);
        end
        if (dur > max_v) begin
            dur = max_v;
        end
        return dur;
    endfunction

endpackage

// File: rtl/wm_sec_prescaler.sv
// Divides the system clock down to a one-cycle seconds tick; can be cleared
// back to zero or frozen at its current count.
module wm_sec_prescaler
    import wm_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int unsigned      CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A tick only counts on a cycle where the count is actually allowed to move.
    assign tick = !clr && !hold && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wm_phase_timer.sv
// Per-phase countdown timer for the washing-machine controller: loads a
// mode-scaled duration, counts seconds down, pauses on open lid, pulses when done.
module wm_phase_timer
    import wm_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned SEC_W    = 12,
    parameter int unsigned SOAK_S   = 300,
    parameter int unsigned WASH_S   = 600,
    parameter int unsigned RINSE_S  = 180,
    parameter int unsigned SPIN_S   = 120
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             timer_enable,
    input  logic [1:0]       phase_sel,
    input  logic             mode1,
    input  logic             mode2,
    input  logic             mode3,
    input  logic             lid,
    output logic             timer_done,
    output logic [SEC_W-1:0] remaining_s,
    output logic             running,
    output logic             paused
);

    timer_state_e     state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [SEC_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             running_q, paused_q;

    logic             active;
    logic             load_req;
    logic             presc_clr;
    logic             presc_hold;
    logic             tick;
    logic [SEC_W-1:0] dur_val;

    assign dur_val    = SEC_W'(dur_lookup(mode1, mode2, mode3, phase_sel,
                                          SOAK_S, WASH_S, RINSE_S, SPIN_S, SEC_W));
    assign active     = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign load_req   = timer_enable && ((state_q == ST_IDLE) || (phase_sel != phase_q));
    assign presc_clr  = !timer_enable || load_req;
    // Only lid=1 stops the count, so a PAUSE cycle with the lid just closed still counts.
    assign presc_hold = lid || !active;

    wm_sec_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (presc_clr),
        .hold  (presc_hold),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        if (!timer_enable) begin
            state_d = ST_IDLE;
            rem_d   = '0;
        end else if (load_req) begin
            state_d = ST_RUN;
            phase_d = phase_sel;
            rem_d   = dur_val;
        end else if (active) begin
            if (lid) begin
                state_d = ST_PAUSE;
            end else begin
                state_d = ST_RUN;
                if (tick) begin
                    if (rem_q == SEC_W'(1)) begin
                        rem_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        rem_d = rem_q - SEC_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            phase_q   <= PH_SOAK;
            rem_q     <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
            running_q <= (state_d == ST_RUN);
            paused_q  <= (state_d == ST_PAUSE);
        end
    end

    assign timer_done  = done_q;
    assign remaining_s = rem_q;
    assign running     = running_q;
    assign paused      = paused_q;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Self-checking bench for wm_phase_timer: directed vector table, multi-cycle
// corner sequences, then random stimulus against an elapsed-time reference model.
module tb_wm_phase_timer;

    localparam int TICK_DIV = 4;
    localparam int SEC_W    = 3;
    localparam int SOAK_S   = 3;
    localparam int WASH_S   = 5;
    localparam int RINSE_S  = 2;
    localparam int SPIN_S   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             timer_enable;
    logic [1:0]       phase_sel;
    logic             mode1, mode2, mode3;
    logic             lid;
    logic             timer_done;
    logic [SEC_W-1:0] remaining_s;
    logic             running;
    logic             paused;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: a phase is finished once dur*TICK_DIV lid-closed cycles have elapsed.
    bit mLoaded, mFinished;
    int mPhase, mDur, mElapsed;
    int expRem;
    bit expDone, expRun, expPause;

    typedef struct {
        bit       rstn;
        bit       en;
        bit [1:0] ph;
        bit       m1, m2, m3, lid;
        int       rem;
        bit       done, run, pause;
    } vec_t;

    vec_t vecs[15];

    wm_phase_timer #(
        .TICK_DIV (TICK_DIV),
        .SEC_W    (SEC_W),
        .SOAK_S   (SOAK_S),
        .WASH_S   (WASH_S),
        .RINSE_S  (RINSE_S),
        .SPIN_S   (SPIN_S)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .timer_enable (timer_enable),
        .phase_sel    (phase_sel),
        .mode1        (mode1),
        .mode2        (mode2),
        .mode3        (mode3),
        .lid          (lid),
        .timer_done   (timer_done),
        .remaining_s  (remaining_s),
        .running      (running),
        .paused       (paused)
    );

    always #5 clk = ~clk;

    function automatic int refDur(input int ph, input bit m1, input bit m2, input bit m3);
        int base;
        int maxv;
        maxv = (1 << SEC_W) - 1;
        case (ph)
            0:       base = SOAK_S;
            1:       base = WASH_S;
            2:       base = RINSE_S;
            default: base = SPIN_S;
        endcase
        if (m1 || !(m2 || m3)) return base;
        if (m2) return (2 * base > maxv) ? maxv : 2 * base;
        return (base / 2 < 1) ? 1 : base / 2;
    endfunction

    function automatic void modelEdge();
        expDone = 1'b0;
        if (!rst_n || !timer_enable) begin
            mLoaded = 1'b0; mFinished = 1'b0; mElapsed = 0;
            expRem = 0; expRun = 1'b0; expPause = 1'b0;
        end else if (!mLoaded || int'(phase_sel) != mPhase) begin
            mLoaded = 1'b1; mFinished = 1'b0; mElapsed = 0;
            mPhase = int'(phase_sel);
            mDur = refDur(mPhase, mode1, mode2, mode3);
            expRem = mDur; expRun = 1'b1; expPause = 1'b0;
        end else if (mFinished) begin
            expRem = 0; expRun = 1'b0; expPause = 1'b0;
        end else if (lid) begin
            expRun = 1'b0; expPause = 1'b1;
            expRem = mDur - mElapsed / TICK_DIV;
        end else begin
            mElapsed++;
            expPause = 1'b0;
            if (mElapsed >= mDur * TICK_DIV) begin
                mFinished = 1'b1; expDone = 1'b1; expRem = 0; expRun = 1'b0;
            end else begin
                expRun = 1'b1;
                expRem = mDur - mElapsed / TICK_DIV;
            end
        end
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        modelEdge();
    endtask

    task automatic applyStimulus(input bit rstn, input bit en, input bit [1:0] ph,
                                 input bit m1, input bit m2, input bit m3, input bit lidIn);
        rst_n        = rstn;
        timer_enable = en;
        phase_sel    = ph;
        mode1        = m1;
        mode2        = m2;
        mode3        = m3;
        lid          = lidIn;
        stepCycle();
    endtask

    // Holds the current inputs until timer_done is seen; at = cycle index or -1 on timeout.
    task automatic waitForDone(input int maxCycles, output int at);
        at = -1;
        for (int i = 1; i <= maxCycles; i++) begin
            stepCycle();
            if (timer_done) begin
                at = i;
                break;
            end
        end
    endtask

    initial begin
        int at;
        int pulses;

        rst_n = 1'b0; timer_enable = 1'b0; phase_sel = 2'b00;
        mode1 = 1'b0; mode2 = 1'b0; mode3 = 1'b0; lid = 1'b0;

        vecs[0]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 7, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].rstn, vecs[i].en, vecs[i].ph,
                          vecs[i].m1, vecs[i].m2, vecs[i].m3, vecs[i].lid);
            checkOutput($sformatf("vec%0d_rem", i),   int'(remaining_s), vecs[i].rem);
            checkOutput($sformatf("vec%0d_done", i),  int'(timer_done),  int'(vecs[i].done));
            checkOutput($sformatf("vec%0d_run", i),   int'(running),     int'(vecs[i].run));
            checkOutput($sformatf("vec%0d_pause", i), int'(paused),      int'(vecs[i].pause));
        end

        // Plain mode1 soak run: 3 s at 4 cycles/s.
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_load_rem", int'(remaining_s), 3);
        waitForDone(40, at);
        checkOutput("t1_done_cycle", at, 12);
        checkOutput("t1_rem_at_done", int'(remaining_s), 0);
        stepCycle();
        checkOutput("t1_done_one_cycle", int'(timer_done), 0);
        checkOutput("t1_not_running", int'(running), 0);

        // Lid open for 7 cycles from cycle 5 delays completion by exactly 7 cycles.
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) stepCycle();
        checkOutput("t2_rem_before_lid", int'(remaining_s), 2);
        lid = 1'b1;
        for (int k = 5; k <= 11; k++) begin
            stepCycle();
            checkOutput($sformatf("t2_paused_k%0d", k), int'(paused), 1);
            checkOutput($sformatf("t2_rem_held_k%0d", k), int'(remaining_s), 2);
        end
        lid = 1'b0;
        waitForDone(30, at);
        checkOutput("t2_done_cycle", 11 + at, 19);

        // Same phase held in DONE: no repeat pulse; then a phase change reloads.
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            stepCycle();
            if (timer_done) pulses++;
        end
        checkOutput("t3_no_repeat_pulse", pulses, 0);
        phase_sel = 2'd1;
        stepCycle();
        checkOutput("t3_reload_rem", int'(remaining_s), 5);
        waitForDone(40, at);
        checkOutput("t3_done_cycle", at, 20);

        // Enable dropped mid-run, and on the final-tick cycle.
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) stepCycle();
        timer_enable = 1'b0;
        stepCycle();
        checkOutput("t5_cancel_rem", int'(remaining_s), 0);
        checkOutput("t5_cancel_running", int'(running), 0);
        checkOutput("t5_cancel_done", int'(timer_done), 0);
        timer_enable = 1'b1;
        stepCycle();
        checkOutput("t5_reload_rem", int'(remaining_s), 3);
        pulses = 0;
        for (int k = 1; k <= 11; k++) begin
            stepCycle();
            if (timer_done) pulses++;
        end
        timer_enable = 1'b0;
        stepCycle();
        if (timer_done) pulses++;
        stepCycle();
        if (timer_done) pulses++;
        checkOutput("t5_final_tick_no_pulse", pulses, 0);

        // Reset mid-wash, then a fresh load.
        applyStimulus(1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) stepCycle();
        rst_n = 1'b0;
        stepCycle();
        checkOutput("t6_reset_rem", int'(remaining_s), 0);
        checkOutput("t6_reset_running", int'(running), 0);
        checkOutput("t6_reset_paused", int'(paused), 0);
        checkOutput("t6_reset_done", int'(timer_done), 0);
        rst_n = 1'b1;
        stepCycle();
        checkOutput("t6_fresh_load_rem", int'(remaining_s), 5);
        checkOutput("t6_fresh_running", int'(running), 1);

        // Randomized stimulus against the reference model.
        for (int c = 0; c < 1500; c++) begin
            bit [1:0] ph;
            ph = phase_sel;
            if ($urandom_range(0, 39) == 0) ph = 2'($urandom_range(0, 3));
            applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 95) != 0, ph,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
            checkOutput("rand_rem",   int'(remaining_s), expRem);
            checkOutput("rand_done",  int'(timer_done),  int'(expDone));
            checkOutput("rand_run",   int'(running),     int'(expRun));
            checkOutput("rand_pause", int'(paused),      int'(expPause));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
